// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch, load and store.
// IDLE -> WAIT -> RESP sequencing; store > load > fetch with a fetch anti-starvation override.
module mem_port_arbiter #(
  parameter int W            = 32,
  parameter int BE_W         = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [W-1:0]    if_addr,
  output logic [W-1:0]    if_rdata,
  output logic            if_ack,
  input  logic            ld_req,
  input  logic [W-1:0]    ld_addr,
  output logic [W-1:0]    ld_rdata,
  output logic            ld_ack,
  input  logic            st_req,
  input  logic [W-1:0]    st_addr,
  input  logic [W-1:0]    st_data,
  input  logic [BE_W-1:0] st_be,
  output logic            st_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [W-1:0]    mem_addr,
  output logic [W-1:0]    mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ready,
  input  logic [W-1:0]    mem_rdata,
  output logic [1:0]      grant,
  output logic            busy
);

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_IF   = 2'b01;
  localparam logic [1:0] G_LD   = 2'b10;
  localparam logic [1:0] G_ST   = 2'b11;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic            we;
    logic [W-1:0]    addr;
    logic [W-1:0]    wdata;
    logic [BE_W-1:0] be;
  } mem_cmd_t;

  state_t     state;
  logic [3:0] streak;
  logic [1:0] win;
  mem_cmd_t   cmd;

  // Fetch wins outright once data-side grants have starved it long enough.
  always_comb begin
    win = G_NONE;
    if (if_req && streak >= LIMIT) win = G_IF;
    else if (st_req)               win = G_ST;
    else if (ld_req)               win = G_LD;
    else if (if_req)               win = G_IF;
  end

  always_comb begin
    cmd = '{we: 1'b0, addr: if_addr, wdata: '0, be: '1};
    case (win)
      G_ST:    cmd = '{we: 1'b1, addr: st_addr, wdata: st_data, be: st_be};
      G_LD:    cmd.addr = ld_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      streak    <= '0;
      grant     <= G_NONE;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ack    <= 1'b0;
      ld_ack    <= 1'b0;
      st_ack    <= 1'b0;
      if_rdata  <= '0;
      ld_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win != G_NONE) begin
            state     <= S_WAIT;
            busy      <= 1'b1;
            grant     <= win;
            mem_req   <= 1'b1;
            mem_we    <= cmd.we;
            mem_addr  <= cmd.addr;
            mem_wdata <= cmd.wdata;
            mem_be    <= cmd.be;
            if (win != G_IF && if_req) begin
              if (streak != 4'hF) streak <= streak + 4'd1;
            end else begin
              streak <= '0;
            end
          end
        end
        S_WAIT: begin
          // Requester-side changes are ignored here; the latched command runs to completion.
          if (mem_ready) begin
            state   <= S_RESP;
            mem_req <= 1'b0;
            case (grant)
              G_IF: begin if_ack <= 1'b1; if_rdata <= mem_rdata; end
              G_LD: begin ld_ack <= 1'b1; ld_rdata <= mem_rdata; end
              G_ST: st_ack <= 1'b1;
              default: ;
            endcase
          end
        end
        S_RESP: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          grant  <= G_NONE;
          if_ack <= 1'b0;
          ld_ack <= 1'b0;
          st_ack <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          grant <= G_NONE;
        end
      endcase
    end
  end

endmodule
